// File: rtl/control_step_counter.sv
// Step counter of the hardwired control unit: holds the current control step,
// decodes it one-hot onto T and sequences by increment, jump or dispatch.
module control_step_counter #(
    parameter int unsigned       STEP_W = 8,
    parameter logic [STEP_W-1:0] TGT_A  = STEP_W'(0),
    parameter logic [STEP_W-1:0] TGT_B  = STEP_W'(8),
    parameter logic [STEP_W-1:0] TGT_C  = STEP_W'(17),
    parameter logic [STEP_W-1:0] TGT_D  = STEP_W'(19),
    parameter logic [STEP_W-1:0] TGT_E  = STEP_W'(41),
    parameter logic [STEP_W-1:0] TGT_F  = STEP_W'(49)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   bruncnd,
    input  logic                   brcnd,
    input  logic                   bropr,
    input  logic                   bradr,
    input  logic [15:0]            signals,
    input  logic [STEP_W-1:0]      mp_addr,
    input  logic [STEP_W-1:0]      adr_addr,
    output logic [STEP_W-1:0]      step,
    output logic [(2**STEP_W)-1:0] T,
    output logic                   seq_err
);

    localparam int unsigned N = 2**STEP_W;

    logic              jump;
    logic [5:0]        sel;
    logic [STEP_W-1:0] target;
    logic [STEP_W-1:0] step_nxt;
    logic              sel_onehot;
    logic [1:0]        n_src;
    logic              conflict;

    assign jump = bruncnd | brcnd;
    assign sel  = signals[15:10];

    // Priority encoder: the highest set select bit wins; no bit set gives step 0.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        target = '0;
        if (sel[5])      target = TGT_A;
        else if (sel[4]) target = TGT_B;
        else if (sel[3]) target = TGT_C;
        else if (sel[2]) target = TGT_D;
        else if (sel[1]) target = TGT_E;
        else if (sel[0]) target = TGT_F;
    end

    always_comb begin
        step_nxt = step + STEP_W'(1);
        if (jump)       step_nxt = target;
        else if (bropr) step_nxt = mp_addr;
        else if (bradr) step_nxt = adr_addr;
    end

    // bruncnd and brcnd together count as a single jump source.
    assign sel_onehot = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    assign n_src      = {1'b0, jump} + {1'b0, bropr} + {1'b0, bradr};
    assign conflict   = (n_src > 2'd1) || (jump && !sel_onehot);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            step    <= '0;
            seq_err <= 1'b0;
        end else if (!hold) begin
            step <= step_nxt;
            if (conflict) seq_err <= 1'b1;
        end
    end

    assign T = N'(1) << step;

endmodule
